fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one FIFO write port between NUM_REQ requesters. It grants at most one requester per cycle and registers the winning word onto the FIFO write interface. It tracks FIFO occupancy with a credit counter, so a write is never issued into a full FIFO, including words still in flight. It sits directly in front of the FIFO write side; the FIFO's read side reports each pop back to the arbiter.

---
 rtl/fifo_wr_arbiter.sv | 89 ++++++++
 tb/tb_fifo_wr_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// A credit counter tracks free FIFO slots, including words still in flight.
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int DEPTH      = 16,
   parameter int CNT_W      = 5
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          fifo_write_en,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   input  logic                          fifo_pop,
   output logic [CNT_W-1:0]              credits,
   output logic                          no_credit,
   output logic                          ovf_err
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [PTR_W-1:0]      rr_ptr;
   logic [PTR_W-1:0]      winner;
   logic [PTR_W:0]        sum;
   logic [PTR_W-1:0]      cand;
   logic                  found;
   logic                  transfer;
   logic                  pop_ok;
   logic [DATA_WIDTH-1:0] words [NUM_REQ];

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Scan from rr_ptr upward with wrap; the first active request wins.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      sum    = '0;
      cand   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
         if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
         cand = sum[PTR_W-1:0];
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // Handshake: a word transfers on the rising edge where req[i] and gnt[i]
   // are both high; a requester holds req and its data stable until granted.
   always_comb begin
      gnt = '0;
      if (reset && (credits != '0) && found) gnt[winner] = 1'b1;
   end

   assign transfer  = |gnt;
   assign pop_ok    = fifo_pop && (credits != FULL);
   assign no_credit = (credits == '0);

   always_ff @(posedge clk) begin
      if (!reset) begin
         fifo_write_en <= 1'b0;
         fifo_data_in  <= '0;
         rr_ptr        <= '0;
         credits       <= FULL;
         ovf_err       <= 1'b0;
      end else begin
         fifo_write_en <= transfer;
         if (transfer) begin
            fifo_data_in <= words[winner];
            rr_ptr       <= (winner == PTR_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
         end
         // A pop with every slot already free means the FIFO and this
         // counter disagree; flag it and keep credits saturated.
         if (fifo_pop && (credits == FULL)) ovf_err <= 1'b1;
         if (transfer && !pop_ok)      credits <= credits - 1'b1;
         else if (!transfer && pop_ok) credits <= credits + 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: grant order, credit accounting, reset.
module tb_fifo_wr_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  gnt;
   logic        fifo_write_en;
   logic [7:0]  fifo_data_in;
   logic        fifo_pop;
   logic [4:0]  credits;
   logic        no_credit;
   logic        ovf_err;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .DEPTH(16), .CNT_W(5)) dut (
      .clk           (clk),
      .reset         (reset),
      .req           (req),
      .req_data      (req_data),
      .gnt           (gnt),
      .fifo_write_en (fifo_write_en),
      .fifo_data_in  (fifo_data_in),
      .fifo_pop      (fifo_pop),
      .credits       (credits),
      .no_credit     (no_credit),
      .ovf_err       (ovf_err)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check the combinational grant for this cycle, record the word it should
   // deliver, then advance to just after the next rising edge.
   task automatic grant_step(input logic [3:0] exp_gnt, input string tag);
      #1;
      check(tag, gnt, exp_gnt);
      for (int i = 0; i < 4; i++) begin
         if (exp_gnt[i]) exp_q.push_back(req_data[i*8 +: 8]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   // scoreboard: every write strobe must carry the next expected word
   always @(negedge clk) begin
      if (fifo_write_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_extra: got write %0h expected no write", fifo_data_in);
         end else begin
            check("sb_data", fifo_data_in, exp_q.pop_front());
         end
      end
   end

   initial begin
      reset    = 1'b0;
      req      = 4'b1111;
      req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      fifo_pop = 1'b0;

      // reset held 3 cycles with all requests up
      repeat (3) begin
         tick();
         check("rst_gnt", gnt, 4'b0000);
         check("rst_wen", fifo_write_en, 1'b0);
         check("rst_credits", credits, 5'd16);
         check("rst_ovf", ovf_err, 1'b0);
      end
      check("rst_data", fifo_data_in, 8'h00);
      check("rst_nocredit", no_credit, 1'b0);
      reset = 1'b1;

      // strict rotation
      grant_step(4'b0001, "rot0");
      grant_step(4'b0010, "rot1");
      grant_step(4'b0100, "rot2");
      grant_step(4'b1000, "rot3");
      grant_step(4'b0001, "rot4");
      check("rot_credits", credits, 5'd11);

      // walk rr_ptr to 3, then skip and wrap with req = 0101
      req = 4'b0010;
      grant_step(4'b0010, "walk1");
      req = 4'b0100;
      grant_step(4'b0100, "walk2");
      req = 4'b0101;
      grant_step(4'b0001, "skip0");
      grant_step(4'b0100, "skip1");
      grant_step(4'b0001, "skip2");
      check("skip_credits", credits, 5'd6);

      // transfer and pop in the same cycle at credits = 5
      req = 4'b0001;
      grant_step(4'b0001, "pre_pop");
      check("credits5", credits, 5'd5);
      fifo_pop = 1'b1;
      grant_step(4'b0001, "pop_xfer");
      fifo_pop = 1'b0;
      check("credits_hold", credits, 5'd5);

      // fill from a fresh reset with one streaming requester
      req = 4'b0000;
      do_reset();
      check("fill_start", credits, 5'd16);
      req = 4'b0001;
      req_data[7:0] = 8'h10;
      for (int k = 0; k < 16; k++) begin
         grant_step(4'b0001, "fill_gnt");
         check("fill_credits", credits, 5'(15 - k));
         req_data[7:0] = req_data[7:0] + 8'h01;
      end
      check("fill_nocredit", no_credit, 1'b1);
      repeat (2) begin
         #1;
         check("stall_gnt", gnt, 4'b0000);
         tick();
      end
      fifo_pop = 1'b1;
      #1;
      check("zero_pop_gnt", gnt, 4'b0000);
      tick();
      fifo_pop = 1'b0;
      check("pop_credit", credits, 5'd1);
      check("pop_nocredit", no_credit, 1'b0);
      grant_step(4'b0001, "regrant");
      check("regrant_wen", fifo_write_en, 1'b1);
      check("regrant_credits", credits, 5'd0);
      #1;
      check("regrant_once", gnt, 4'b0000);
      req = 4'b0000;
      tick();

      // overflow at credits = 16
      do_reset();
      fifo_pop = 1'b1;
      tick();
      fifo_pop = 1'b0;
      check("ovf_set", ovf_err, 1'b1);
      check("ovf_credits", credits, 5'd16);
      tick();
      check("ovf_sticky", ovf_err, 1'b1);

      // reset in the middle of a burst squashes the pending word
      req      = 4'b1111;
      req_data = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
      grant_step(4'b0001, "burst0");
      grant_step(4'b0010, "burst1");
      check("burst_credits", credits, 5'd14);
      reset = 1'b0;
      #1;
      check("mid_rst_gnt", gnt, 4'b0000);
      tick();
      check("mid_rst_wen", fifo_write_en, 1'b0);
      check("mid_rst_credits", credits, 5'd16);
      check("mid_rst_ovf", ovf_err, 1'b0);
      check("mid_rst_data", fifo_data_in, 8'h00);
      req   = 4'b0000;
      reset = 1'b1;
      tick();
      tick();
      check("sb_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
